// File: rtl/uc_xfer_master_if.sv
// rtl/uc_xfer_master_if.sv - command and byte-stream handshake bundle for uc_xfer_master
// Purpose: groups the upstream-facing handshakes of uc_xfer_master.
// Signals:
//   cmd_valid/cmd_ready, cmd_write, cmd_addr[14:0], cmd_len[15:0]  command
//   wr_data[7:0], wr_valid, wr_ready                               stream -> SRAM
//   rd_data[7:0], rd_valid, rd_ready                               SRAM -> stream
//   busy, done, err                                                status
// Modports: master (the transfer engine), slave (the upstream loader).
interface uc_xfer_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [14:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err
  );
endinterface

// File: rtl/uc_xfer_master.sv
// rtl/uc_xfer_master.sv - uC-side master sequencing the CPLD uc_* SRAM port
// Purpose: accepts {direction, 15-bit address, byte count} commands, loads the
//   CPLD address pointer with lo/hi strobes, then moves one byte per four-phase
//   uc_write/uc_read handshake, pulsing strobe_addr after every byte so the
//   CPLD post-increments its pointer.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   bus (master)       cmd_*, wr_* / rd_* byte streams, busy/done/err status
//   uc_data            shared 8-bit bus, driven only while uc_oe is set
//   uc_write, uc_read  registered CPLD requests, never both high
//   set_addr_lo/hi     address byte select for strobe_addr
//   strobe_addr        rising edge latches an address byte or increments it
//   uc_ack             asynchronous CPLD acknowledge, 2-FF synchronised
// Config: define UC_XFER_TIMEOUT_EN to bound each ack wait to TIMEOUT_CYC cycles.
module uc_xfer_master #(
  parameter int STROBE_CYC = 2
`ifdef UC_XFER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  uc_xfer_master_if.master bus,
  inout  wire  [7:0]       uc_data,
  output logic             uc_write,
  output logic             uc_read,
  output logic             set_addr_lo,
  output logic             set_addr_hi,
  output logic             strobe_addr,
  input  logic             uc_ack
);

  localparam int SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  typedef enum logic [4:0] {
    IDLE, ALO_SU, ALO_STB, ALO_HD, AHI_SU, AHI_STB, AHI_HD,
    FETCH, REQ, ACK_HI, RD_HOLD, ACK_LO, INC_SU, INC_STB, INC_HD, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] cnt_q;
  logic           phase_done;
  logic           ack_m, ack_s;
  logic           write_q;
  logic [14:0]    addr_q;
  logic [15:0]    rem_q;
  logic [7:0]     wr_byte_q;
  logic [7:0]     rd_data_q;
  logic           rd_valid_q;
  logic           busy_q;
  logic           uc_oe;
  logic [7:0]     uc_dout;
  logic           cmd_ready_c;
  logic           wr_ready_c;
  logic           done_c;
  logic           to_fire;

`ifdef UC_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;
  logic          to_hit;
  logic          err_q;
  assign to_hit  = (to_q == TW'(TIMEOUT_CYC - 1));
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign uc_data       = uc_oe ? uc_dout : 8'bz;
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.wr_ready  = wr_ready_c;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_c;

  assign phase_done = (cnt_q == SCW'(STROBE_CYC - 1));

  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    wr_ready_c  = 1'b0;
    done_c      = 1'b0;
    set_addr_lo = 1'b0;
    set_addr_hi = 1'b0;
    strobe_addr = 1'b0;
    uc_oe       = 1'b0;
    uc_dout     = wr_byte_q;
    to_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) state_d = (bus.cmd_len == '0) ? DONE : ALO_SU;
      end
      ALO_SU, ALO_STB, ALO_HD: begin
        set_addr_lo = 1'b1;
        uc_oe       = 1'b1;
        uc_dout     = addr_q[7:0];
        strobe_addr = (state_q == ALO_STB);
        if (phase_done) begin
          if (state_q == ALO_SU)       state_d = ALO_STB;
          else if (state_q == ALO_STB) state_d = ALO_HD;
          else                         state_d = AHI_SU;
        end
      end
      AHI_SU, AHI_STB, AHI_HD: begin
        set_addr_hi = 1'b1;
        uc_oe       = 1'b1;
        uc_dout     = {1'b0, addr_q[14:8]};
        strobe_addr = (state_q == AHI_STB);
        if (phase_done) begin
          if (state_q == AHI_SU)       state_d = AHI_STB;
          else if (state_q == AHI_STB) state_d = AHI_HD;
          else                         state_d = write_q ? FETCH : REQ;
        end
      end
      FETCH: begin
        wr_ready_c = bus.wr_valid;
        if (bus.wr_valid) state_d = REQ;
      end
      // Requests are registered: uc_read first shows in ACK_HI, so for reads
      // REQ is the bus turnaround cycle with uc_data already released.
      REQ: begin
        uc_oe   = write_q;
        state_d = ACK_HI;
      end
      ACK_HI: begin
        uc_oe = write_q;
        if (ack_s) state_d = write_q ? ACK_LO : RD_HOLD;
`ifdef UC_XFER_TIMEOUT_EN
        else if (to_hit) begin
          to_fire = 1'b1;
          state_d = DONE;
        end
`endif
      end
      RD_HOLD: begin
        if (bus.rd_ready) state_d = ACK_LO;
      end
      ACK_LO: begin
        uc_oe = write_q;
        if (!ack_s) state_d = INC_SU;
`ifdef UC_XFER_TIMEOUT_EN
        else if (to_hit) begin
          to_fire = 1'b1;
          state_d = DONE;
        end
`endif
      end
      // Both selects low: the strobe tells the CPLD to post-increment.
      INC_SU, INC_STB, INC_HD: begin
        strobe_addr = (state_q == INC_STB);
        if (phase_done) begin
          if (state_q == INC_SU)       state_d = INC_STB;
          else if (state_q == INC_STB) state_d = INC_HD;
          else if (rem_q != '0)        state_d = write_q ? FETCH : REQ;
          else                         state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_m      <= 1'b0;
      ack_s      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      wr_byte_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      uc_write   <= 1'b0;
      uc_read    <= 1'b0;
`ifdef UC_XFER_TIMEOUT_EN
      to_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_m   <= uc_ack;
      ack_s   <= ack_m;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;

      if (state_q == IDLE && bus.cmd_valid) begin
        write_q <= bus.cmd_write;
        addr_q  <= bus.cmd_addr;
        rem_q   <= bus.cmd_len;
        busy_q  <= (bus.cmd_len != '0);
`ifdef UC_XFER_TIMEOUT_EN
        err_q   <= 1'b0;
`endif
      end
      if (state_q == FETCH && bus.wr_valid) wr_byte_q <= bus.wr_data;
      if (state_q == REQ) begin
        uc_write <= write_q;
        uc_read  <= !write_q;
      end
      if (state_q == ACK_HI && ack_s) begin
        uc_write <= 1'b0;
        uc_read  <= 1'b0;
        if (!write_q) begin
          rd_data_q  <= uc_data;
          rd_valid_q <= 1'b1;
        end
      end
      if (state_q == RD_HOLD && bus.rd_ready) rd_valid_q <= 1'b0;
      if (state_q == ACK_LO && !ack_s) rem_q <= rem_q - 1'b1;
      if (state_d == DONE) busy_q <= 1'b0;

`ifdef UC_XFER_TIMEOUT_EN
      to_q <= (state_d != state_q) ? '0 : to_q + 1'b1;
      if (to_fire) begin
        uc_write   <= 1'b0;
        uc_read    <= 1'b0;
        rd_valid_q <= 1'b0;
        err_q      <= 1'b1;
      end
`endif
    end
  end

endmodule
